prg_loader: RTL and testbench

PRG_LOADER -- requirements
Module: prg_loader

---
 rtl/nes_pkg.sv | 21 ++
 rtl/sync_pulse.sv | 39 +++
 rtl/prg_loader.sv | 156 +++++++++++++++
 tb/tb_prg_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/nes_pkg.sv
// Shared definitions for the NES cartridge loader: FSM encoding, command
// nibble, region indices and the checksum helper.
package nes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4
  } ldr_state_e;

  localparam logic [3:0] CMD_NIBBLE = 4'hA;
  localparam logic [3:0] REGION_PRG = 4'd0;
  localparam logic [3:0] REGION_CHR = 4'd1;

  function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] b);
    return sum + b;
  endfunction

endpackage

// File: rtl/sync_pulse.sv
// Two-flop synchroniser plus registered rising-edge detect for a slow
// cross-domain level; emits one clk-wide pulse per rising edge.
module sync_pulse (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic level_i,
  output logic pulse_o
);

  logic       ff1_q;
  logic       ff2_q;
  logic       ff3_q;
  logic [1:0] vld_q;
  logic       armed_q;
  logic       pulse_q;

  // Edge detection only arms once a genuine post-reset low has been seen,
  // so a level already high at reset release cannot fire a pulse.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      ff1_q   <= 1'b0;
      ff2_q   <= 1'b0;
      ff3_q   <= 1'b0;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      ff1_q   <= level_i;
      ff2_q   <= ff1_q;
      ff3_q   <= ff2_q;
      vld_q   <= {vld_q[0], 1'b1};
      armed_q <= armed_q | (vld_q[1] & ~ff2_q);
      pulse_q <= ff2_q & ~ff3_q & armed_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/prg_loader.sv
// UART frame loader: parses {A,region} / length / data / checksum frames and
// streams the payload into the selected cartridge memory region.
module prg_loader
  import nes_pkg::*;
#(
  parameter int REGION_CNT  = 2,
  parameter int ADDR_W      = 15,
  parameter int TIMEOUT_CYC = 5000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_ready,
  output logic              wr_en,
  output logic [3:0]        wr_region,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [31:0] MAX_LEN  = 32'd1 << ADDR_W;
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
  localparam logic [4:0]  RGN_CNT  = 5'(REGION_CNT);

  logic              strobe_s;
  ldr_state_e        state_q;
  logic [7:0]        len_lo_q;
  logic [15:0]       rem_q;
  logic [ADDR_W-1:0] addr_cnt_q;
  logic [7:0]        csum_q;
  logic [31:0]       tmo_q;
  logic              wr_en_q;
  logic [3:0]        wr_region_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [15:0] len_d;
  logic        cmd_ok_d;
  logic        len_big_d;

  sync_pulse u_sync (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .level_i  (rx_ready),
    .pulse_o  (strobe_s)
  );

  assign len_d     = {rx_byte, len_lo_q};
  assign cmd_ok_d  = (rx_byte[7:4] == CMD_NIBBLE) && ({1'b0, rx_byte[3:0]} < RGN_CNT);
  assign len_big_d = {16'd0, len_d} > MAX_LEN;

  // Frame FSM; every output is registered here, pulses default low each cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      len_lo_q    <= 8'd0;
      rem_q       <= 16'd0;
      addr_cnt_q  <= '0;
      csum_q      <= 8'd0;
      tmo_q       <= 32'd0;
      wr_en_q     <= 1'b0;
      wr_region_q <= REGION_PRG;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if (strobe_s) begin
        tmo_q <= 32'd0;
        case (state_q)
          ST_IDLE: begin
            if (cmd_ok_d) begin
              state_q     <= ST_LEN_LO;
              busy_q      <= 1'b1;
              wr_region_q <= rx_byte[3:0];
              csum_q      <= 8'd0;
            end else begin
              err_q <= 1'b1;
            end
          end
          ST_LEN_LO: begin
            len_lo_q <= rx_byte;
            state_q  <= ST_LEN_HI;
          end
          ST_LEN_HI: begin
            if (len_big_d) begin
              err_q   <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else if (len_d == 16'd0) begin
              state_q <= ST_CSUM;
            end else begin
              rem_q      <= len_d;
              addr_cnt_q <= '0;
              state_q    <= ST_DATA;
            end
          end
          ST_DATA: begin
            wr_en_q    <= 1'b1;
            wr_addr_q  <= addr_cnt_q;
            wr_data_q  <= rx_byte;
            addr_cnt_q <= addr_cnt_q + 1'b1;
            csum_q     <= csum_add(csum_q, rx_byte);
            rem_q      <= rem_q - 16'd1;
            if (rem_q == 16'd1) begin
              state_q <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            if (rx_byte == csum_q) begin
              done_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end else if (state_q != ST_IDLE) begin
        // Silence mid-frame: abort once the idle gap reaches TIMEOUT_CYC.
        if (tmo_q == TMO_LAST) begin
          err_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
          tmo_q   <= 32'd0;
        end else begin
          tmo_q <= tmo_q + 32'd1;
        end
      end else begin
        tmo_q <= 32'd0;
      end
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_region = wr_region_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prg_loader.sv
// Scoreboard bench for prg_loader: directed frames push expected events,
// a negedge monitor pops and compares whatever the DUT emits.
module tb_prg_loader;

  localparam int TB_TMO = 300;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [7:0]  rx_byte;
  logic        rx_ready;
  logic        wr_en;
  logic [3:0]  wr_region;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct packed {
    logic [1:0]  kind;   // 0 write, 1 done, 2 err
    logic [3:0]  region;
    logic [14:0] addr;
    logic [7:0]  data;
    logic        tmo_chk;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_wr_cyc = 0;
  logic [7:0] tb_mem [0:1][0:15];

  prg_loader #(.REGION_CNT(2), .ADDR_W(15), .TIMEOUT_CYC(TB_TMO)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx_byte   (rx_byte),
    .rx_ready  (rx_ready),
    .wr_en     (wr_en),
    .wr_region (wr_region),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic handle_event(input ev_t act);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_event: got kind=%0d region=%0d addr=%0h data=%02h, required none",
               act.kind, act.region, act.addr, act.data);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if ({e.kind, e.region, e.addr, e.data} != {act.kind, act.region, act.addr, act.data}) begin
        failures++;
        $display("FAIL event: got kind=%0d region=%0d addr=%0h data=%02h, required kind=%0d region=%0d addr=%0h data=%02h",
                 act.kind, act.region, act.addr, act.data, e.kind, e.region, e.addr, e.data);
      end
      if (e.tmo_chk) begin
        checks++;
        if (cyc - last_wr_cyc != TB_TMO) begin
          failures++;
          $display("FAIL timeout_delay: got %0d cycles, required %0d", cyc - last_wr_cyc, TB_TMO);
        end
      end
    end
  endtask

  // Monitor: sample away from the active edge and score every output event.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (done && err) begin
        checks++;
        failures++;
        $display("FAIL done_err_overlap: got done=1 err=1, required not both");
      end
      if (wr_en) begin
        handle_event({2'd0, wr_region, wr_addr, wr_data, 1'b0});
        checks++;
        if (busy !== 1'b1) begin
          failures++;
          $display("FAIL busy_during_write: got %b, required 1", busy);
        end
        if (wr_region < 4'd2 && wr_addr < 15'd16) tb_mem[wr_region[0]][wr_addr[3:0]] = wr_data;
        last_wr_cyc = cyc;
      end
      if (done || err) begin
        handle_event({(done ? 2'd1 : 2'd2), 4'd0, 15'd0, 8'd0, 1'b0});
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL busy_at_end: got %b, required 0", busy);
        end
      end
    end
  end

  task automatic exp_wr(input logic [3:0] r, input logic [14:0] a, input logic [7:0] d);
    exp_q.push_back({2'd0, r, a, d, 1'b0});
  endtask

  task automatic exp_end(input logic [1:0] kind, input logic tmo);
    exp_q.push_back({kind, 4'd0, 15'd0, 8'd0, tmo});
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_byte  = b;
    rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1 rx_ready = 1'b0;
    repeat (6) @(posedge clk);
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    repeat (8) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: got %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk);
    checks++;
    if ({wr_en, busy, done, err, wr_region, wr_addr, wr_data} !== '0) begin
      failures++;
      $display("FAIL %s: got wr_en=%b busy=%b done=%b err=%b region=%0d addr=%0h data=%02h, required all zero",
               name, wr_en, busy, done, err, wr_region, wr_addr, wr_data);
    end
  endtask

  task automatic check_mem(input int r, input int a, input logic [7:0] d);
    checks++;
    if (tb_mem[r][a] !== d) begin
      failures++;
      $display("FAIL mem_r%0d_a%0d: got %02h, required %02h", r, a, tb_mem[r][a], d);
    end
  endtask

  task automatic frame_a0_basic();
    exp_wr(4'd0, 15'd0, 8'h11);
    exp_wr(4'd0, 15'd1, 8'h22);
    exp_wr(4'd0, 15'd2, 8'h33);
    exp_wr(4'd0, 15'd3, 8'h44);
    exp_end(2'd1, 1'b0);
    send_byte(8'hA0); send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'hAA);
  endtask

  initial begin
    for (int r = 0; r < 2; r++)
      for (int a = 0; a < 16; a++) tb_mem[r][a] = 8'h00;

    // Reset with rx_ready already high: the held level must not strobe.
    reset_n  = 1'b0;
    rx_ready = 1'b1;
    rx_byte  = 8'h55;
    repeat (3) @(posedge clk);
    check_reset_outputs("reset_values");
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 rx_ready = 1'b0;
    repeat (6) @(posedge clk);
    wait_drain("no_strobe_after_reset", 10);

    frame_a0_basic();
    wait_drain("frame_prg", 100);
    check_mem(0, 0, 8'h11); check_mem(0, 3, 8'h44);

    // CHR frame with a bad checksum: writes stay, err reported.
    exp_wr(4'd1, 15'd0, 8'hFF);
    exp_wr(4'd1, 15'd1, 8'h01);
    exp_end(2'd2, 1'b0);
    send_byte(8'hA1); send_byte(8'h02); send_byte(8'h00);
    send_byte(8'hFF); send_byte(8'h01); send_byte(8'h01);
    wait_drain("frame_chr_bad_sum", 100);
    check_mem(1, 0, 8'hFF); check_mem(1, 1, 8'h01);

    // Bad command nibble, then out-of-range region.
    exp_end(2'd2, 1'b0);
    exp_end(2'd2, 1'b0);
    send_byte(8'h55); send_byte(8'hA7);
    wait_drain("bad_cmds", 100);

    // Zero-length frame, then over-long length.
    exp_end(2'd1, 1'b0);
    send_byte(8'hA0); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    wait_drain("zero_len", 100);
    exp_end(2'd2, 1'b0);
    send_byte(8'hA0); send_byte(8'h01); send_byte(8'h80);
    wait_drain("len_8001", 100);

    // Silence mid-DATA must abort exactly TB_TMO cycles after the last strobe.
    exp_wr(4'd0, 15'd0, 8'h01);
    exp_wr(4'd0, 15'd1, 8'h02);
    exp_end(2'd2, 1'b1);
    send_byte(8'hA0); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02);
    wait_drain("timeout", TB_TMO + 100);

    // Reset during DATA: silent abort, then a fresh frame completes.
    exp_wr(4'd0, 15'd0, 8'h11);
    exp_wr(4'd0, 15'd1, 8'h22);
    send_byte(8'hA0); send_byte(8'h04); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22);
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    check_reset_outputs("reset_mid_frame");
    #1 reset_n = 1'b1;
    repeat (10) @(posedge clk);
    wait_drain("reset_abort", 20);
    frame_a0_basic();
    wait_drain("frame_after_reset", 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
